hazard_unit: RTL
================

# hazard_unit

Pipeline hazard controller for the 5-stage RV32 core. It generates the fetch enables (EN1 for the PC, EN2 for IF/ID), the ID/EX flush, the back-end hold, and the EX-stage forwarding selects. It also sequences multi-cycle data-memory waits through a small FSM with a timeout watchdog, and keeps saturating stall and flush statistics. It sits beside the datapath and drives the enable and flush inputs of every pipeline register.

## Interface
- TIMEOUT, 16: consecutive MemBusyM cycles that trigger ERROR; must be ≥ 2
- CNT_W, 16: width of the statistics counters
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  5  source registers of the instruction in Decode
- Rs1E, Rs2E, RdE  in  5  source and destination registers in Execute
- ResultSrcE0  in  1  the Execute instruction is a load
- PCSrcE  in  1  branch or jump taken in Execute
- RegWriteM, RdM  in  1, 5  Memory-stage write-back info
- RegWriteW, RdW  in  1, 5  Writeback-stage write-back info
- MemBusyM  in  1  data memory not ready; the whole pipeline must freeze
- EN1  out  1  PC enable
- EN2  out  1  IF/ID enable
- EN3  out  1  ID/EX, EX/MEM and MEM/WB enable
- FlushD  out  1  clear IF/ID
- FlushE  out  1  clear ID/EX
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 register file, 01 W result, 10 M ALU result
- Timeout  out  1  sticky; set in ERROR
- State  out  2  FSM state (debug)
- StallCycles  out  CNT_W  saturating count of stall or freeze cycles
- FlushCount  out  CNT_W  saturating count of redirect flushes

## Operation
- lwStall = ResultSrcE0 & (RdE≠0) & (RdE==Rs1D | RdE==Rs2D).
- ForwardAE:
  - 10 if RegWriteM & RdM≠0 & RdM==Rs1E;
  - else 01 if RegWriteW & RdW≠0 & RdW==Rs1E;
  - else 00.
  - ForwardBE is identical, using Rs2E. M has priority over W.
  - Forwarding is combinational in every state.
- FSM states:
  - RUN = 00
  - WAIT = 01
  - ERROR = 10
- Outputs in RUN or WAIT with MemBusyM=0:
  - EN3=1
  - EN1 = EN2 = ~lwStall | PCSrcE
  - FlushD = PCSrcE
  - FlushE = lwStall | PCSrcE
  - If lwStall and PCSrcE are both set, the redirect wins and EN1=EN2=1.
- Outputs in any state with MemBusyM=1, and always in ERROR:
  - EN1=EN2=EN3=0, FlushD=FlushE=0.
  - The freeze overrides any pending flush. PCSrcE is re-evaluated after the freeze releases.
- Transitions:
  - RUN → WAIT on MemBusyM=1, with WaitCnt ← 1.
  - WAIT → RUN on MemBusyM=0, with WaitCnt ← 0.
  - WAIT with MemBusyM=1: if WaitCnt==TIMEOUT−1 → ERROR, else WaitCnt++.
  - ERROR is terminal until rst.
- Statistics:
  - StallCycles increments on any cycle with (lwStall & ~PCSrcE) | MemBusyM | State==ERROR.
  - FlushCount increments on any cycle with FlushD=1.
  - Both counters saturate at all-ones.
- Timeout = (State==ERROR).

## Timing
- All control outputs are Mealy and combinational from current inputs and State. They take effect at the next rising clk.
- Load-use costs exactly one bubble. In the following cycle RdE holds the bubble (0), so lwStall clears.
- Redirect costs two cycles: the D and E contents are flushed at the edge after PCSrcE=1.
- MemBusyM for N consecutive cycles (N < TIMEOUT) freezes for exactly N cycles. The pipeline advances on the first cycle MemBusyM=0.
- MemBusyM high for TIMEOUT consecutive cycles enters ERROR at the TIMEOUT-th edge.
- While rst=0, asynchronously:
  - State=RUN, WaitCnt=0, counters=0, Timeout=0.
  - EN1=EN2=EN3=0, FlushD=FlushE=0, ForwardAE=ForwardBE=00.
- Reset mid-WAIT or mid-ERROR returns to RUN. Normal operation starts on the first edge after rst rises.
- Register index 0 never triggers a stall or a forward.

## Structure
- Package hazard_pkg holds:
  - state encodings RUN/WAIT/ERROR;
  - forward-select constants FWD_RF=00, FWD_WB=01, FWD_MEM=10.
- Sub-module forwarding_unit: one combinational priority compare (Rs, RdM, RegWriteM, RdW, RegWriteW → 2-bit select). It is instantiated twice, once for operand A and once for B.
- The FSM, WaitCnt ($clog2(TIMEOUT) bits) and the saturating counters live in hazard_unit.

## Test plan
- Forwarding priority: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 → ForwardAE=10. Drop RegWriteM → 01. Set RdM=RdW=0 → 00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 → EN1=EN2=0, FlushE=1, FlushD=0 for one cycle. Next cycle, with RdE=0 → EN1=EN2=1 and StallCycles=1.
- Redirect: PCSrcE=1 for one cycle → FlushD=FlushE=1, EN1=1 and FlushCount=1. Repeat with lwStall also set → EN1=EN2=1.
- Memory wait: MemBusyM=1 for 3 cycles with PCSrcE=1 → EN1=EN2=EN3=0 and no flush for 3 cycles, State=01. Then MemBusyM=0 → State=00, FlushD=1 and StallCycles +3.
- Timeout: with TIMEOUT=16, MemBusyM held high for 16 cycles → State=10 and Timeout=1 after the 16th edge, all enables 0 even after MemBusyM drops. Asserting rst → State=00, counters 0.
- Saturation: with CNT_W=4, 20 forced stall cycles → StallCycles=15 and no wrap.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and
// EX-stage operand forwarding selects.
package hazard_pkg;

    // Memory-wait sequencer states
    localparam logic [1:0] RUN   = 2'b00;
    localparam logic [1:0] WAIT  = 2'b01;
    localparam logic [1:0] ERROR = 2'b10;

    // ALU operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle between the datapath and the hazard controller. The datapath
// (master) supplies register indices and stage status; the hazard unit
// (slave) returns enables, flushes, forwarding selects and statistics.
interface hazard_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic [4:0]       RdE;
    logic             ResultSrcE0;
    logic             PCSrcE;
    logic             RegWriteM;
    logic [4:0]       RdM;
    logic             RegWriteW;
    logic [4:0]       RdW;
    logic             MemBusyM;

    logic             EN1;
    logic             EN2;
    logic             EN3;
    logic             FlushD;
    logic             FlushE;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             Timeout;
    logic [1:0]       State;
    logic [CNT_W-1:0] StallCycles;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE0, PCSrcE,
               RegWriteM, RdM, RegWriteW, RdW, MemBusyM,
        input  EN1, EN2, EN3, FlushD, FlushE, ForwardAE, ForwardBE,
               Timeout, State, StallCycles, FlushCount
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE0, PCSrcE,
               RegWriteM, RdM, RegWriteW, RdW, MemBusyM,
        output EN1, EN2, EN3, FlushD, FlushE, ForwardAE, ForwardBE,
               Timeout, State, StallCycles, FlushCount
    );

endinterface

// File: rtl/forwarding_unit.sv
// Single-operand forwarding select: the Memory stage result is the most
// recent value, so it wins over Writeback. Register x0 is never forwarded.
module forwarding_unit
    import hazard_pkg::*;
(
    input  logic [4:0] Rs,
    input  logic [4:0] RdM,
    input  logic       RegWriteM,
    input  logic [4:0] RdW,
    input  logic       RegWriteW,
    output logic [1:0] Forward
);

    // Priority compare M over W over register file
    always_comb begin
        Forward = FWD_RF;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs)) begin
            Forward = FWD_MEM;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs)) begin
            Forward = FWD_WB;
        end else begin
            Forward = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage RV32 core: load-use stall,
// branch redirect flush, data-memory wait freeze with timeout watchdog,
// EX-stage forwarding and saturating stall/flush statistics.
// All control outputs are Mealy (current inputs + state) and are forced
// inactive while rst is low.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 16,   // consecutive busy cycles to ERROR, >= 2
    parameter int CNT_W   = 16
) (
    input logic          clk,
    input logic          rst,
    hazard_unit_if.slave hz
);

    localparam int               WC_W    = $clog2(TIMEOUT);
    localparam logic [WC_W-1:0]  WC_ONE  = WC_W'(1);
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       stateR;
    logic [WC_W-1:0]  waitCntR;
    logic [CNT_W-1:0] stallCntR;
    logic [CNT_W-1:0] flushCntR;

    logic             lwStallS;
    logic             freezeS;
    logic             stallIncS;
    logic [1:0]       fwdAS;
    logic [1:0]       fwdBS;
    logic             en1S;
    logic             en2S;
    logic             en3S;
    logic             flushDS;
    logic             flushES;
    logic [1:0]       fwdAOutS;
    logic [1:0]       fwdBOutS;

    forwarding_unit uFwdA (
        .Rs        (hz.Rs1E),
        .RdM       (hz.RdM),
        .RegWriteM (hz.RegWriteM),
        .RdW       (hz.RdW),
        .RegWriteW (hz.RegWriteW),
        .Forward   (fwdAS)
    );

    forwarding_unit uFwdB (
        .Rs        (hz.Rs2E),
        .RdM       (hz.RdM),
        .RegWriteM (hz.RegWriteM),
        .RdW       (hz.RdW),
        .RegWriteW (hz.RegWriteW),
        .Forward   (fwdBS)
    );

    // Hazard detection: load in EX feeding an instruction in D, and the
    // conditions that freeze the whole pipe (memory busy or watchdog trip)
    always_comb begin
        lwStallS  = hz.ResultSrcE0 && (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
        // Any state other than RUN/WAIT (including the unused encoding)
        // is treated as a frozen pipe
        freezeS   = hz.MemBusyM || ((stateR != RUN) && (stateR != WAIT));
        stallIncS = (lwStallS && !hz.PCSrcE) || hz.MemBusyM || (stateR == ERROR);
    end

    // Enable/flush/forward outputs; freeze overrides redirect and stall,
    // redirect overrides the load-use stall, reset silences everything
    always_comb begin
        en1S     = 1'b0;
        en2S     = 1'b0;
        en3S     = 1'b0;
        flushDS  = 1'b0;
        flushES  = 1'b0;
        fwdAOutS = FWD_RF;
        fwdBOutS = FWD_RF;
        if (!rst) begin
            en1S     = 1'b0;
            en2S     = 1'b0;
            en3S     = 1'b0;
            flushDS  = 1'b0;
            flushES  = 1'b0;
            fwdAOutS = FWD_RF;
            fwdBOutS = FWD_RF;
        end else if (freezeS) begin
            fwdAOutS = fwdAS;
            fwdBOutS = fwdBS;
        end else begin
            en1S     = !lwStallS || hz.PCSrcE;
            en2S     = !lwStallS || hz.PCSrcE;
            en3S     = 1'b1;
            flushDS  = hz.PCSrcE;
            flushES  = lwStallS || hz.PCSrcE;
            fwdAOutS = fwdAS;
            fwdBOutS = fwdBS;
        end
    end

    // Memory-wait sequencer with timeout watchdog; ERROR holds until reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateR   <= RUN;
            waitCntR <= '0;
        end else begin
            case (stateR)
                RUN: begin
                    if (hz.MemBusyM) begin
                        stateR   <= WAIT;
                        waitCntR <= WC_ONE;
                    end else begin
                        stateR   <= RUN;
                        waitCntR <= '0;
                    end
                end
                WAIT: begin
                    if (!hz.MemBusyM) begin
                        stateR   <= RUN;
                        waitCntR <= '0;
                    end else if (waitCntR == WC_LAST) begin
                        stateR   <= ERROR;
                    end else begin
                        waitCntR <= waitCntR + WC_ONE;
                    end
                end
                ERROR: begin
                    stateR <= ERROR;
                end
                default: begin
                    // Unused encoding: fail safe into the trapped state
                    stateR <= ERROR;
                end
            endcase
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCntR <= '0;
            flushCntR <= '0;
        end else begin
            if (stallIncS && (stallCntR != CNT_MAX)) begin
                stallCntR <= stallCntR + CNT_ONE;
            end
            if (flushDS && (flushCntR != CNT_MAX)) begin
                flushCntR <= flushCntR + CNT_ONE;
            end
        end
    end

    assign hz.EN1         = en1S;
    assign hz.EN2         = en2S;
    assign hz.EN3         = en3S;
    assign hz.FlushD      = flushDS;
    assign hz.FlushE      = flushES;
    assign hz.ForwardAE   = fwdAOutS;
    assign hz.ForwardBE   = fwdBOutS;
    assign hz.Timeout     = (stateR == ERROR);
    assign hz.State       = stateR;
    assign hz.StallCycles = stallCntR;
    assign hz.FlushCount  = flushCntR;

endmodule
